spi_mem_ctrl: RTL and testbench
===============================

Name: spi_mem_ctrl

Overview:
- Parametrised SPI NOR/SRAM access controller; next generation of the CPU's single-mode fetch reader.
- Executes one read (0x03) or write (0x02) transaction of 1..MAX_BYTES bytes per request.
- Uses a valid/ready request port and a single-cycle response pulse; serves both instruction fetch and load/store.
- SPI mode 0, MSB first, byte data little-endian toward the core.

Parameters:
- ADDR_W, 24, address bits sent on the bus; legal values 16, 24, 32.
- MAX_BYTES, 4, maximum data bytes per transaction; legal values 1..4.
- CLK_DIV, 1, clk cycles per SCLK half-period; minimum 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_write  in  1  1 = write (0x02), 0 = read (0x03)
- req_addr  in  ADDR_W  byte address
- req_len  in  2  byte count minus 1
- req_wdata  in  8*MAX_BYTES  write data; byte 0 is in [7:0]
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  8*MAX_BYTES  read data; held until the next accept
- sclk  out  1  SPI clock
- mosi  out  1  SPI data out
- cs_n  out  1  SPI chip select, active low
- miso  in  1  SPI data in

Behaviour:
- Reset: sclk=0, mosi=0, cs_n=1, req_ready=1, rsp_valid=0, rsp_rdata=0.
- Reset mid-transaction aborts on that edge with the same values; no rsp_valid is issued.
- States: IDLE, CMD, ADDR, DATA, DONE.
- IDLE:
  - req_ready=1.
  - Accept occurs when req_valid && req_ready on edge T0.
  - Latch write, addr, wdata and nbytes = min(req_len+1, MAX_BYTES).
  - Clear rsp_rdata. Go to CMD.
- Bit timing:
  - From T0+1: cs_n=0, sclk=0, mosi = first bit (MSB of command).
  - Each bit is a low phase of CLK_DIV cycles, then a high phase of CLK_DIV cycles.
  - mosi changes only at the start of a low phase.
  - miso is sampled on the clk edge that ends each high phase.
- CMD: 8 bits (0x03 or 0x02), then go to ADDR.
- ADDR: ADDR_W bits, MSB first, then go to DATA.
- DATA, read:
  - Receive 8*nbytes bits.
  - Received byte k goes to rsp_rdata[8k+7:8k], MSB first within the byte.
  - Unused upper bytes stay 0.
- DATA, write:
  - Send req_wdata byte 0 first, then byte 1, and so on, MSB first within each byte.
  - mosi=0 after the last bit.
- End of transaction:
  - After the final high phase: sclk=0, cs_n=1, rsp_valid=1 for exactly one cycle; enter DONE.
- DONE: one cycle with req_ready=0, guaranteeing cs_n high for at least 2 clk cycles. Then return to IDLE.
- req_ready=0 in every state except IDLE.
- req_* inputs are ignored while busy and are not sampled after accept.
- Latency: accept edge to rsp_valid edge = 1 + 2*CLK_DIV*(8+ADDR_W+8*nbytes) cycles.
  - Example: ADDR_W=24, CLK_DIV=1, 4 bytes gives 129 cycles.
- Back-to-back: a request held valid during DONE is accepted on the first IDLE cycle.
- rsp_rdata after a write is 0.
- A counter wraps only within a phase; addresses are not incremented internally.

Optional Feature:
- Macro: SPI_MEM_FAST_READ_EN
- Defined:
  - Reads use command 0x0B.
  - ADDR is followed by a DUMMY state of 8 SCLK cycles, with mosi=0 and miso ignored.
  - Read latency grows by 16*CLK_DIV cycles.
  - Writes are unchanged.
- Undefined: DUMMY state and its counters are absent; reads use 0x03.

Test Plan:
- Read, defaults: addr=0x000010, len=3; SPI model returns 0x13,0x00,0x05,0x93 -> mosi carries 0x03,0x00,0x00,0x10; rsp_rdata=0x93050013; rsp_valid 129 cycles after accept; 64 sclk rising edges.
- Write, len=1: addr=0x0000A0, wdata=0x0000BEEF -> mosi carries 0x02,0x00,0x00,0xA0,0xEF,0xBE; cs_n rises with rsp_valid; rsp_rdata=0.
- len=3 with MAX_BYTES=2 -> only 2 data bytes transferred; rsp_rdata[15:0] filled.
- CLK_DIV=3: single-byte read -> each sclk phase 3 cycles; latency 1+6*40=241 cycles.
- rst_n low mid-ADDR -> next edge cs_n=1, sclk=0, req_ready=1; no rsp_valid; a following read completes correctly.
- Back-to-back: req_valid held high for two reads -> cs_n high exactly 2 cycles between transactions.

Source files
------------

// File: rtl/spi_mem_ctrl.sv
// SPI mode-0 memory controller: one read (0x03) or write (0x02) of 1..MAX_BYTES bytes per request.
// Optional build macro SPI_MEM_FAST_READ_EN: reads use 0x0B followed by 8 dummy SCLK cycles.
module spi_mem_ctrl #(
   parameter int unsigned ADDR_W    = 24,
   parameter int unsigned MAX_BYTES = 4,
   parameter int unsigned CLK_DIV   = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_write,
   input  logic [ADDR_W-1:0]      req_addr,
   input  logic [1:0]             req_len,
   input  logic [8*MAX_BYTES-1:0] req_wdata,
   output logic                   rsp_valid,
   output logic [8*MAX_BYTES-1:0] rsp_rdata,
   output logic                   sclk,
   output logic                   mosi,
   output logic                   cs_n,
   input  logic                   miso
);

   localparam int unsigned      SH_W     = 32;
   localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [1:0]       NB_MAX   = 2'(MAX_BYTES - 1);
   localparam logic [7:0]       CMD_WR   = 8'h02;
`ifdef SPI_MEM_FAST_READ_EN
   localparam logic [7:0]       CMD_RD   = 8'h0B;
`else
   localparam logic [7:0]       CMD_RD   = 8'h03;
`endif

   typedef enum logic [2:0] {
      StIdle,
      StCmd,
      StAddr,
`ifdef SPI_MEM_FAST_READ_EN
      StDummy,
`endif
      StData,
      StDone
   } state_e;

   state_e                 r_state, w_state;
   logic [DIV_W-1:0]       r_div, w_div;
   logic                   r_sclk, w_sclk;
   logic                   r_mosi, w_mosi;
   logic                   r_cs_n, w_cs_n;
   logic                   r_rsp, w_rsp;
   logic [5:0]             r_bit, w_bit;
   logic [SH_W-1:0]        r_sh, w_sh;
   logic [6:0]             r_rx, w_rx;
   logic [8*MAX_BYTES-1:0] r_rdata, w_rdata;
   logic                   r_write, w_write;
   logic [ADDR_W-1:0]      r_addr, w_addr;
   logic [8*MAX_BYTES-1:0] r_wdata, w_wdata;
   logic [1:0]             r_nbm1, w_nbm1;

   logic [7:0]             w_cmd;
   logic [SH_W-1:0]        w_addr_sh;
   logic [SH_W-1:0]        w_data_sh;
   logic [7:0]             w_rx_byte;
   logic [1:0]             w_rx_k;
   logic [5:0]             w_data_bits;

   assign w_cmd       = req_write ? CMD_WR : CMD_RD;
   assign w_addr_sh   = SH_W'(r_addr) << (SH_W - ADDR_W);
   assign w_rx_byte   = {r_rx, miso};
   // Received bits count down through the data phase, so the byte index runs upward.
   assign w_rx_k      = r_nbm1 - r_bit[4:3];
   assign w_data_bits = {1'b0, r_nbm1, 3'b111};

   // Write data goes out byte 0 first; left-align it so the shifter's MSB is the next bit.
   always_comb begin
      w_data_sh = '0;
      if (r_write) begin
         for (int unsigned b = 0; b < MAX_BYTES; b++) begin
            w_data_sh[SH_W-1-8*b -: 8] = r_wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= StIdle;
         r_div   <= '0;
         r_sclk  <= 1'b0;
         r_mosi  <= 1'b0;
         r_cs_n  <= 1'b1;
         r_rsp   <= 1'b0;
         r_bit   <= '0;
         r_sh    <= '0;
         r_rx    <= '0;
         r_rdata <= '0;
         r_write <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_nbm1  <= '0;
      end else begin
         r_state <= w_state;
         r_div   <= w_div;
         r_sclk  <= w_sclk;
         r_mosi  <= w_mosi;
         r_cs_n  <= w_cs_n;
         r_rsp   <= w_rsp;
         r_bit   <= w_bit;
         r_sh    <= w_sh;
         r_rx    <= w_rx;
         r_rdata <= w_rdata;
         r_write <= w_write;
         r_addr  <= w_addr;
         r_wdata <= w_wdata;
         r_nbm1  <= w_nbm1;
      end
   end

   always_comb begin
      w_state = r_state;
      w_div   = r_div;
      w_sclk  = r_sclk;
      w_mosi  = r_mosi;
      w_cs_n  = r_cs_n;
      w_rsp   = 1'b0;
      w_bit   = r_bit;
      w_sh    = r_sh;
      w_rx    = r_rx;
      w_rdata = r_rdata;
      w_write = r_write;
      w_addr  = r_addr;
      w_wdata = r_wdata;
      w_nbm1  = r_nbm1;

      case (r_state)
         StIdle: begin
            if (req_valid) begin
               w_state = StCmd;
               w_write = req_write;
               w_addr  = req_addr;
               w_wdata = req_wdata;
               w_nbm1  = (req_len > NB_MAX) ? NB_MAX : req_len;
               w_rdata = '0;
               w_rx    = '0;
               w_cs_n  = 1'b0;
               w_sclk  = 1'b0;
               w_div   = '0;
               w_bit   = 6'd7;
               w_sh    = {w_cmd, 24'd0};
               w_mosi  = w_cmd[7];
            end
         end

         StDone: begin
            w_state = StIdle;
         end

         default: begin
            if (r_div != DIV_LAST) begin
               w_div = r_div + DIV_W'(1);
            end else begin
               w_div = '0;
               if (!r_sclk) begin
                  w_sclk = 1'b1;
               end else begin
                  // End of a high phase: sample miso, then start the next low phase.
                  w_sclk = 1'b0;
                  if (r_state == StData && !r_write) begin
                     w_rx = w_rx_byte[6:0];
                     if (r_bit[2:0] == 3'd0) begin
                        for (int unsigned b = 0; b < MAX_BYTES; b++) begin
                           if (w_rx_k == 2'(b)) begin
                              w_rdata[8*b +: 8] = w_rx_byte;
                           end
                        end
                     end
                  end

                  if (r_bit != 6'd0) begin
                     w_bit  = r_bit - 6'd1;
                     w_sh   = r_sh << 1;
                     w_mosi = r_sh[SH_W-2];
                  end else begin
                     case (r_state)
                        StCmd: begin
                           w_state = StAddr;
                           w_bit   = 6'(ADDR_W - 1);
                           w_sh    = w_addr_sh;
                           w_mosi  = w_addr_sh[SH_W-1];
                        end
                        StAddr: begin
`ifdef SPI_MEM_FAST_READ_EN
                           if (!r_write) begin
                              w_state = StDummy;
                              w_bit   = 6'd7;
                              w_sh    = '0;
                              w_mosi  = 1'b0;
                           end else begin
                              w_state = StData;
                              w_bit   = w_data_bits;
                              w_sh    = w_data_sh;
                              w_mosi  = w_data_sh[SH_W-1];
                           end
`else
                           w_state = StData;
                           w_bit   = w_data_bits;
                           w_sh    = w_data_sh;
                           w_mosi  = w_data_sh[SH_W-1];
`endif
                        end
`ifdef SPI_MEM_FAST_READ_EN
                        StDummy: begin
                           w_state = StData;
                           w_bit   = w_data_bits;
                           w_sh    = w_data_sh;
                           w_mosi  = w_data_sh[SH_W-1];
                        end
`endif
                        default: begin
                           w_state = StDone;
                           w_cs_n  = 1'b1;
                           w_rsp   = 1'b1;
                           w_mosi  = 1'b0;
                        end
                     endcase
                  end
               end
            end
         end
      endcase
   end

   assign req_ready = (r_state == StIdle);
   assign rsp_valid = r_rsp;
   assign rsp_rdata = r_rdata;
   assign sclk      = r_sclk;
   assign mosi      = r_mosi;
   assign cs_n      = r_cs_n;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Directed bench for spi_mem_ctrl: default instance (A) and a MAX_BYTES=2, CLK_DIV=3 instance (B).
`timescale 1ns/1ps
module tb_spi_mem_ctrl;

`ifdef SPI_MEM_FAST_READ_EN
   localparam int FAST = 1;
`else
   localparam int FAST = 0;
`endif
   localparam logic [7:0] RD_CMD = (FAST != 0) ? 8'h0B : 8'h03;
   localparam int DBASE = 32 + 8 * FAST;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;
   int cyc = 0;
   always @(posedge clk) cyc++;

   int ntot = 0;
   int nbad = 0;

   logic        a_valid, a_ready, a_write, a_rsp, a_sclk, a_mosi, a_cs_n, a_miso;
   logic [23:0] a_addr;
   logic [1:0]  a_len;
   logic [31:0] a_wdata, a_rdata;

   logic        b_valid, b_ready, b_write, b_rsp, b_sclk, b_mosi, b_cs_n, b_miso;
   logic [23:0] b_addr;
   logic [1:0]  b_len;
   logic [15:0] b_wdata, b_rdata;

   spi_mem_ctrl #(.ADDR_W(24), .MAX_BYTES(4), .CLK_DIV(1)) u_a (
      .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_ready(a_ready),
      .req_write(a_write), .req_addr(a_addr), .req_len(a_len), .req_wdata(a_wdata),
      .rsp_valid(a_rsp), .rsp_rdata(a_rdata), .sclk(a_sclk), .mosi(a_mosi),
      .cs_n(a_cs_n), .miso(a_miso)
   );

   spi_mem_ctrl #(.ADDR_W(24), .MAX_BYTES(2), .CLK_DIV(3)) u_b (
      .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_ready(b_ready),
      .req_write(b_write), .req_addr(b_addr), .req_len(b_len), .req_wdata(b_wdata),
      .rsp_valid(b_rsp), .rsp_rdata(b_rdata), .sclk(b_sclk), .mosi(b_mosi),
      .cs_n(b_cs_n), .miso(b_miso)
   );

   // SPI memory models: capture mosi on sclk rise, present the next reply bit on sclk fall.
   logic [31:0]  a_reply, b_reply;
   logic [0:127] a_cap, b_cap;
   int           a_nrise, b_nrise;

   function automatic logic reply_bit(input logic [31:0] rep, input int n);
      int j;
      if (n < DBASE) return 1'b0;
      j = n - DBASE;
      if (j >= 32) return 1'b0;
      return rep[8 * (j / 8) + 7 - (j % 8)];
   endfunction

   function automatic logic [7:0] cap_byte(input logic [0:127] cap, input int m);
      logic [7:0] r;
      for (int k = 0; k < 8; k++) r[7-k] = cap[8*m+k];
      return r;
   endfunction

   always @(negedge a_cs_n) begin a_nrise = 0; a_miso = reply_bit(a_reply, 0); end
   always @(posedge a_sclk) begin if (a_nrise < 128) a_cap[a_nrise] = a_mosi; a_nrise++; end
   always @(negedge a_sclk) a_miso = reply_bit(a_reply, a_nrise);
   always @(negedge b_cs_n) begin b_nrise = 0; b_miso = reply_bit(b_reply, 0); end
   always @(posedge b_sclk) begin if (b_nrise < 128) b_cap[b_nrise] = b_mosi; b_nrise++; end
   always @(negedge b_sclk) b_miso = reply_bit(b_reply, b_nrise);

   // Length of the most recent completed sclk high and low runs of instance B, in clk cycles.
   int   b_run = 0, b_last_hi = 0, b_last_lo = 0;
   logic b_prev = 1'b0;
   always @(negedge clk) begin
      if (b_sclk != b_prev) begin
         if (b_prev) b_last_hi = b_run;
         else b_last_lo = b_run;
         b_run = 1;
      end else begin
         b_run++;
      end
      b_prev = b_sclk;
   end

   // Issue one request on A (called at a negedge); returns accept-to-response latency.
   task automatic run_a(input logic wr, input logic [23:0] addr, input logic [1:0] len,
                        input logic [31:0] wdata, output int lat, output logic got);
      int t;
      int acc;
      a_write = wr; a_addr = addr; a_len = len; a_wdata = wdata; a_valid = 1'b1;
      t = 0;
      while (!a_ready && t < 16) begin @(negedge clk); t++; end
      acc = cyc + 1;
      @(negedge clk);
      a_valid = 1'b0; a_addr = 24'hFFFFFF; a_wdata = '1; a_write = ~wr; a_len = 2'd0;
      t = 0;
      while (!a_rsp && t < 4000) begin @(negedge clk); t++; end
      got = a_rsp;
      lat = cyc + 1 - acc;
   endtask

   task automatic run_b(input logic wr, input logic [23:0] addr, input logic [1:0] len,
                        input logic [15:0] wdata, output int lat, output logic got);
      int t;
      int acc;
      b_write = wr; b_addr = addr; b_len = len; b_wdata = wdata; b_valid = 1'b1;
      t = 0;
      while (!b_ready && t < 16) begin @(negedge clk); t++; end
      acc = cyc + 1;
      @(negedge clk);
      b_valid = 1'b0; b_addr = 24'hFFFFFF; b_wdata = '1; b_write = ~wr; b_len = 2'd0;
      t = 0;
      while (!b_rsp && t < 8000) begin @(negedge clk); t++; end
      got = b_rsp;
      lat = cyc + 1 - acc;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      ntot++; if (a_cs_n !== 1'b1) begin nbad++; $display("FAIL rst_cs_n: got %b want 1", a_cs_n); end
      ntot++; if (a_sclk !== 1'b0) begin nbad++; $display("FAIL rst_sclk: got %b want 0", a_sclk); end
      ntot++; if (a_mosi !== 1'b0) begin nbad++; $display("FAIL rst_mosi: got %b want 0", a_mosi); end
      ntot++; if (a_ready !== 1'b1) begin nbad++; $display("FAIL rst_ready: got %b want 1", a_ready); end
      ntot++; if (a_rsp !== 1'b0) begin nbad++; $display("FAIL rst_rsp: got %b want 0", a_rsp); end
      ntot++; if (a_rdata !== 32'h0) begin nbad++; $display("FAIL rst_rdata: got %h want 0", a_rdata); end
      ntot++; if (b_cs_n !== 1'b1) begin nbad++; $display("FAIL rst_b_cs_n: got %b want 1", b_cs_n); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_read();
      int lat;
      logic got;
      a_reply = 32'h93050013;
      run_a(1'b0, 24'h000010, 2'd3, 32'h0, lat, got);
      ntot++; if (got !== 1'b1) begin nbad++; $display("FAIL rd_rsp: got %b want 1", got); end
      ntot++; if (lat != 129 + 16 * FAST) begin nbad++; $display("FAIL rd_latency: got %0d want %0d", lat, 129 + 16 * FAST); end
      ntot++; if ({cap_byte(a_cap, 0), cap_byte(a_cap, 1), cap_byte(a_cap, 2), cap_byte(a_cap, 3)} !== {RD_CMD, 24'h000010})
         begin nbad++; $display("FAIL rd_mosi: got %h want %h", {cap_byte(a_cap, 0), cap_byte(a_cap, 1),
            cap_byte(a_cap, 2), cap_byte(a_cap, 3)}, {RD_CMD, 24'h000010}); end
      ntot++; if (a_rdata !== 32'h93050013) begin nbad++; $display("FAIL rd_rdata: got %h want 93050013", a_rdata); end
      ntot++; if (a_nrise != 64 + 8 * FAST) begin nbad++; $display("FAIL rd_sclk_edges: got %0d want %0d", a_nrise, 64 + 8 * FAST); end
      @(negedge clk);
      ntot++; if (a_rsp !== 1'b0) begin nbad++; $display("FAIL rd_rsp_pulse: got %b want 0", a_rsp); end
      ntot++; if (a_rdata !== 32'h93050013) begin nbad++; $display("FAIL rd_rdata_hold: got %h want 93050013", a_rdata); end
   endtask

   task automatic test_write();
      int lat;
      logic got;
      a_reply = 32'hFFFFFFFF;
      run_a(1'b1, 24'h0000A0, 2'd1, 32'h0000BEEF, lat, got);
      ntot++; if (got !== 1'b1) begin nbad++; $display("FAIL wr_rsp: got %b want 1", got); end
      ntot++; if (lat != 97) begin nbad++; $display("FAIL wr_latency: got %0d want 97", lat); end
      ntot++; if ({cap_byte(a_cap, 0), cap_byte(a_cap, 1), cap_byte(a_cap, 2), cap_byte(a_cap, 3)} !== 32'h020000A0)
         begin nbad++; $display("FAIL wr_mosi_hdr: got %h want 020000a0", {cap_byte(a_cap, 0), cap_byte(a_cap, 1),
            cap_byte(a_cap, 2), cap_byte(a_cap, 3)}); end
      ntot++; if ({cap_byte(a_cap, 5), cap_byte(a_cap, 4)} !== 16'hBEEF)
         begin nbad++; $display("FAIL wr_mosi_data: got %h want beef", {cap_byte(a_cap, 5), cap_byte(a_cap, 4)}); end
      ntot++; if (a_nrise != 48) begin nbad++; $display("FAIL wr_sclk_edges: got %0d want 48", a_nrise); end
      ntot++; if (a_cs_n !== 1'b1) begin nbad++; $display("FAIL wr_cs_n_end: got %b want 1", a_cs_n); end
      ntot++; if (a_mosi !== 1'b0 || a_sclk !== 1'b0)
         begin nbad++; $display("FAIL wr_idle_lines: got mosi=%b sclk=%b want 0 0", a_mosi, a_sclk); end
      ntot++; if (a_rdata !== 32'h0) begin nbad++; $display("FAIL wr_rdata: got %h want 0", a_rdata); end
      @(negedge clk);
   endtask

   task automatic test_len_cap();
      int lat;
      logic got;
      b_reply = 32'h44332211;
      run_b(1'b0, 24'h123456, 2'd3, 16'h0, lat, got);
      ntot++; if (got !== 1'b1) begin nbad++; $display("FAIL cap_rsp: got %b want 1", got); end
      ntot++; if (b_rdata !== 16'h2211) begin nbad++; $display("FAIL cap_rdata: got %h want 2211", b_rdata); end
      ntot++; if (b_nrise != 48 + 8 * FAST) begin nbad++; $display("FAIL cap_sclk_edges: got %0d want %0d", b_nrise, 48 + 8 * FAST); end
      ntot++; if (lat != 289 + 48 * FAST) begin nbad++; $display("FAIL cap_latency: got %0d want %0d", lat, 289 + 48 * FAST); end
      ntot++; if ({cap_byte(b_cap, 0), cap_byte(b_cap, 1), cap_byte(b_cap, 2), cap_byte(b_cap, 3)} !== {RD_CMD, 24'h123456})
         begin nbad++; $display("FAIL cap_mosi: got %h want %h", {cap_byte(b_cap, 0), cap_byte(b_cap, 1),
            cap_byte(b_cap, 2), cap_byte(b_cap, 3)}, {RD_CMD, 24'h123456}); end
      @(negedge clk);
   endtask

   task automatic test_clkdiv();
      int lat;
      logic got;
      b_reply = 32'h000000A5;
      run_b(1'b0, 24'h00ABCD, 2'd0, 16'h0, lat, got);
      ntot++; if (got !== 1'b1) begin nbad++; $display("FAIL div_rsp: got %b want 1", got); end
      ntot++; if (lat != 241 + 48 * FAST) begin nbad++; $display("FAIL div_latency: got %0d want %0d", lat, 241 + 48 * FAST); end
      ntot++; if (b_rdata !== 16'h00A5) begin nbad++; $display("FAIL div_rdata: got %h want 00a5", b_rdata); end
      ntot++; if (b_nrise != 40 + 8 * FAST) begin nbad++; $display("FAIL div_sclk_edges: got %0d want %0d", b_nrise, 40 + 8 * FAST); end
      @(negedge clk);
      ntot++; if (b_last_hi != 3) begin nbad++; $display("FAIL div_high_phase: got %0d want 3", b_last_hi); end
      ntot++; if (b_last_lo != 3) begin nbad++; $display("FAIL div_low_phase: got %0d want 3", b_last_lo); end
   endtask

   task automatic test_reset_mid();
      int lat;
      int nrsp;
      logic got;
      a_reply = 32'h11111111;
      a_write = 1'b0; a_addr = 24'h000040; a_len = 2'd0; a_valid = 1'b1;
      @(negedge clk);
      a_valid = 1'b0;
      repeat (20) @(negedge clk);
      ntot++; if (!(a_nrise > 8 && a_nrise < 32))
         begin nbad++; $display("FAIL mid_in_addr: got %0d edges want 9..31", a_nrise); end
      rst_n = 1'b0;
      @(negedge clk);
      ntot++; if (a_cs_n !== 1'b1 || a_sclk !== 1'b0 || a_ready !== 1'b1 || a_rsp !== 1'b0)
         begin nbad++; $display("FAIL mid_abort: got cs_n=%b sclk=%b ready=%b rsp=%b want 1 0 1 0",
            a_cs_n, a_sclk, a_ready, a_rsp); end
      rst_n = 1'b1;
      nrsp = 0;
      repeat (200) begin @(negedge clk); if (a_rsp) nrsp++; end
      ntot++; if (nrsp != 0) begin nbad++; $display("FAIL mid_no_rsp: got %0d pulses want 0", nrsp); end
      a_reply = 32'hDDCCBBAA;
      run_a(1'b0, 24'h000050, 2'd1, 32'h0, lat, got);
      ntot++; if (got !== 1'b1) begin nbad++; $display("FAIL mid_next_rsp: got %b want 1", got); end
      ntot++; if (a_rdata !== 32'h0000BBAA) begin nbad++; $display("FAIL mid_next_rdata: got %h want 0000bbaa", a_rdata); end
      ntot++; if (lat != 97 + 16 * FAST) begin nbad++; $display("FAIL mid_next_latency: got %0d want %0d", lat, 97 + 16 * FAST); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int t;
      int hi;
      a_reply = 32'h78563412;
      a_write = 1'b0; a_addr = 24'h000100; a_len = 2'd3; a_valid = 1'b1;
      @(negedge clk);
      a_addr = 24'h000200;
      t = 0;
      while (!a_rsp && t < 4000) begin @(negedge clk); t++; end
      ntot++; if (a_rdata !== 32'h78563412) begin nbad++; $display("FAIL b2b_rdata0: got %h want 78563412", a_rdata); end
      ntot++; if (cap_byte(a_cap, 2) !== 8'h01) begin nbad++; $display("FAIL b2b_addr0: got %h want 01", cap_byte(a_cap, 2)); end
      hi = 0; t = 0;
      while (a_cs_n && t < 20) begin hi++; @(negedge clk); t++; end
      ntot++; if (hi != 2) begin nbad++; $display("FAIL b2b_cs_gap: got %0d want 2", hi); end
      a_valid = 1'b0;
      a_reply = 32'hCAFEF00D;
      t = 0;
      while (!a_rsp && t < 4000) begin @(negedge clk); t++; end
      ntot++; if (a_rsp !== 1'b1) begin nbad++; $display("FAIL b2b_rsp1: got %b want 1", a_rsp); end
      ntot++; if (a_rdata !== 32'hCAFEF00D) begin nbad++; $display("FAIL b2b_rdata1: got %h want cafef00d", a_rdata); end
      ntot++; if (cap_byte(a_cap, 2) !== 8'h02) begin nbad++; $display("FAIL b2b_addr1: got %h want 02", cap_byte(a_cap, 2)); end
      @(negedge clk);
   endtask

   initial begin
      a_valid = 1'b0; a_write = 1'b0; a_addr = '0; a_len = '0; a_wdata = '0; a_miso = 1'b0;
      b_valid = 1'b0; b_write = 1'b0; b_addr = '0; b_len = '0; b_wdata = '0; b_miso = 1'b0;
      a_reply = '0; b_reply = '0; a_cap = '0; b_cap = '0; a_nrise = 0; b_nrise = 0;
      rst_n = 1'b0;
      @(negedge clk);
      test_reset();
      test_read();
      test_write();
      test_len_cap();
      test_clkdiv();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", ntot, nbad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
